uart_tx_ctrl: RTL and testbench

Frame sequencer for UART transmit. It owns one external parallel-in/serial-out shift register (PISO) and drives its load and shift strobes. It generates the baud timing, the start bit and the stop bit, and presents a valid/ready byte interface upstream. It sits between the byte source (FIFO or command logic) and the PISO/TX pin in the UART TX path.

---
 rtl/uart_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer.
// Owns an external PISO shift register (load/shift strobes) and generates
// baud timing, start bit and stop bit(s) around the PISO's serial output.
// Upstream sees a valid/ready byte interface that only accepts in IDLE.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, o_ready high, waiting for i_valid
// S_START | line low for one bit time; PISO loaded on first cycle
// S_DATA  | line follows PISO serial out, one shift per bit boundary
// S_STOP  | line high for STOP_BITS bit times, then o_done pulse
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic [DATA_BITS-1:0] o_piso_data,
  output logic                 o_piso_load,
  output logic                 o_piso_shift,
  input  logic                 i_piso_serial,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  // Width guards keep the counters at least one bit wide for tiny
  // parameter choices (e.g. DATA_BITS=1).
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] bit_idx_next;
  logic             bit_end;
  logic             accept;
  logic             load_next;
  logic             done_next;

  assign bit_end = (baud_cnt == CNT_LAST);

  // Next-state, bit index and combinational outputs for the frame sequence.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    load_next    = 1'b0;
    done_next    = 1'b0;
    accept       = 1'b0;
    o_ready      = 1'b0;
    o_busy       = 1'b1;
    o_tx         = 1'b1;
    o_piso_shift = 1'b0;

    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        accept  = i_valid;
        if (i_valid) begin
          state_next   = S_START;
          load_next    = 1'b1;
          bit_idx_next = '0;
        end
      end

      S_START: begin
        o_tx = 1'b0;
        if (bit_end) begin
          state_next   = S_DATA;
          bit_idx_next = '0;
        end
      end

      S_DATA: begin
        // PISO bit 0 is already the current data bit; no extra register
        // stage so the line changes exactly on the bit boundary.
        o_tx = i_piso_serial;
        if (bit_end) begin
          if (bit_idx == IDX_DATA_LAST) begin
            state_next   = S_STOP;
            bit_idx_next = '0;
          end else begin
            o_piso_shift = 1'b1;
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end

      S_STOP: begin
        // bit_idx is reused to count stop bits.
        if (bit_end) begin
          if (bit_idx == IDX_STOP_LAST) begin
            state_next   = S_IDLE;
            done_next    = 1'b1;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Baud counter restarts on every state entry and wraps at bit end.
    if ((state_next != state) || bit_end) begin
      baud_cnt_next = '0;
    end else begin
      baud_cnt_next = baud_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Baud counter and bit index registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
    end
  end

  // Registered PISO data/load and frame-done pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_piso_data <= '0;
      o_piso_load <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      if (accept) begin
        o_piso_data <= i_data;
      end
      o_piso_load <= load_next;
      o_done      <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: self-checking bench for uart_tx_ctrl with behavioural PISOs.
// Two instances: A (4 clk/bit, 1 stop bit) and B (3 clk/bit, 2 stop bits).
module tb_uart_tx_ctrl;

  localparam int DB    = 8;
  localparam int CPB_A = 4;
  localparam int SB_A  = 1;
  localparam int CPB_B = 3;
  localparam int SB_B  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          a_valid;
  logic [DB-1:0] a_data;
  logic          a_ready;
  logic [DB-1:0] a_pdata;
  logic          a_load;
  logic          a_shift;
  logic          a_serial;
  logic          a_tx;
  logic          a_busy;
  logic          a_done;
  logic [DB-1:0] a_piso = '0;

  logic          b_valid;
  logic [DB-1:0] b_data;
  logic          b_ready;
  logic [DB-1:0] b_pdata;
  logic          b_load;
  logic          b_shift;
  logic          b_serial;
  logic          b_tx;
  logic          b_busy;
  logic          b_done;
  logic [DB-1:0] b_piso = '0;

  int errors = 0;
  int checks = 0;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB), .STOP_BITS(SB_A)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_valid(a_valid), .i_data(a_data),
    .o_ready(a_ready), .o_piso_data(a_pdata), .o_piso_load(a_load),
    .o_piso_shift(a_shift), .i_piso_serial(a_serial), .o_tx(a_tx),
    .o_busy(a_busy), .o_done(a_done)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB), .STOP_BITS(SB_B)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_valid(b_valid), .i_data(b_data),
    .o_ready(b_ready), .o_piso_data(b_pdata), .o_piso_load(b_load),
    .o_piso_shift(b_shift), .i_piso_serial(b_serial), .o_tx(b_tx),
    .o_busy(b_busy), .o_done(b_done)
  );

  // Behavioural PISOs: load wins, shift moves toward bit 0.
  always @(posedge clk) begin
    if (a_load) a_piso <= a_pdata;
    else if (a_shift) a_piso <= {1'b0, a_piso[DB-1:1]};
  end
  always @(posedge clk) begin
    if (b_load) b_piso <= b_pdata;
    else if (b_shift) b_piso <= {1'b0, b_piso[DB-1:1]};
  end
  assign a_serial = a_piso[0];
  assign b_serial = b_piso[0];

  // Reference model: c is the cycle offset from the accept cycle (c=0).
  // Frame slots: slot 0 start bit, slots 1..DB data LSB first, then stop/idle.
  function automatic logic m_tx(input logic [DB-1:0] b, input int cpb, input int c);
    int slot;
    if (c < 1) return 1'b1;
    slot = (c - 1) / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= DB) return b[slot-1];
    return 1'b1;
  endfunction

  function automatic int m_len(input int cpb, input int sb);
    return (1 + DB + sb) * cpb;
  endfunction

  // Packed expectation {tx, load, shift, done, busy, ready}.
  function automatic logic [5:0] m_vec(input logic [DB-1:0] b, input int cpb,
                                       input int sb, input int c);
    logic busy;
    logic shift;
    busy  = (c >= 1) && (c <= m_len(cpb, sb));
    shift = (c >= 2 * cpb) && (c <= DB * cpb) && ((c % cpb) == 0);
    return {m_tx(b, cpb, c), (c == 1), shift, (c == m_len(cpb, sb) + 1), busy, !busy};
  endfunction

  localparam logic [5:0] IDLE_VEC = 6'b100001;

  // Sends one byte on A and checks every cycle; optional busy-time pulse.
  task automatic frame_a(input logic [DB-1:0] b, input int pulse_at,
                         input logic [DB-1:0] pulse_byte, input string tag);
    int n;
    logic [5:0] got;
    logic [5:0] exp;
    n = 0;
    while (a_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait ready=%b required=1", tag, a_ready);
      return;
    end
    a_valid = 1'b1;
    a_data  = b;
    for (int c = 1; c <= m_len(CPB_A, SB_A) + 2; c++) begin
      @(posedge clk); #1;
      a_valid = (c == pulse_at);
      a_data  = (c == pulse_at) ? pulse_byte : 8'($urandom);
      got = {a_tx, a_load, a_shift, a_done, a_busy, a_ready};
      exp = m_vec(b, CPB_A, SB_A, c);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s c=%0d {tx,load,shift,done,busy,ready} got=%b required=%b",
                 tag, c, got, exp);
      end
      checks++;
      if (a_pdata !== b) begin
        errors++;
        $display("FAIL %s c=%0d piso_data got=%h required=%h", tag, c, a_pdata, b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({a_tx, a_load, a_shift, a_done, a_busy, a_ready, a_pdata} !== {IDLE_VEC, 8'h00}) begin
      errors++;
      $display("FAIL reset_a got=%b required=%b",
               {a_tx, a_load, a_shift, a_done, a_busy, a_ready, a_pdata}, {IDLE_VEC, 8'h00});
    end
    checks++;
    if ({b_tx, b_load, b_shift, b_done, b_busy, b_ready, b_pdata} !== {IDLE_VEC, 8'h00}) begin
      errors++;
      $display("FAIL reset_b got=%b required=%b",
               {b_tx, b_load, b_shift, b_done, b_busy, b_ready, b_pdata}, {IDLE_VEC, 8'h00});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_soak();
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_tx, a_load, a_shift, a_done, a_busy, a_ready} !== IDLE_VEC) begin
        errors++;
        $display("FAIL idle_soak c=%0d got=%b required=%b", c,
                 {a_tx, a_load, a_shift, a_done, a_busy, a_ready}, IDLE_VEC);
      end
    end
  endtask

  task automatic test_basic();
    frame_a(8'hA5, -1, 8'h00, "basic_a5");
  endtask

  task automatic test_back_to_back();
    logic [5:0] got;
    logic [5:0] exp;
    int t2;
    t2 = m_len(CPB_A, SB_A) + 1;
    a_valid = 1'b1;
    a_data  = 8'h00;
    for (int c = 1; c <= t2 + m_len(CPB_A, SB_A) + 2; c++) begin
      @(posedge clk); #1;
      a_data  = 8'hFF;
      a_valid = (c <= t2);
      got = {a_tx, a_load, a_shift, a_done, a_busy, a_ready};
      exp = (c <= t2) ? m_vec(8'h00, CPB_A, SB_A, c) : m_vec(8'hFF, CPB_A, SB_A, c - t2);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back c=%0d {tx,load,shift,done,busy,ready} got=%b required=%b",
                 c, got, exp);
      end
      checks++;
      if (a_pdata !== ((c <= t2) ? 8'h00 : 8'hFF)) begin
        errors++;
        $display("FAIL back_to_back c=%0d piso_data got=%h required=%h",
                 c, a_pdata, (c <= t2) ? 8'h00 : 8'hFF);
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_busy_ignore();
    frame_a(8'hA5, 10, 8'h3C, "busy_ignore");
    for (int c = 0; c < 3 * CPB_A; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_tx, a_busy, a_pdata} !== {1'b1, 1'b0, 8'hA5}) begin
        errors++;
        $display("FAIL busy_ignore_tail c=%0d {tx,busy,pdata} got=%b required=%b",
                 c, {a_tx, a_busy, a_pdata}, {1'b1, 1'b0, 8'hA5});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] b;
    logic [5:0] got;
    b = 8'($urandom);
    a_valid = 1'b1;
    a_data  = b;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      a_valid = 1'b0;
      got = {a_tx, a_load, a_shift, a_done, a_busy, a_ready};
      checks++;
      if (got !== m_vec(b, CPB_A, SB_A, c)) begin
        errors++;
        $display("FAIL reset_mid_pre c=%0d got=%b required=%b", c, got, m_vec(b, CPB_A, SB_A, c));
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({a_tx, a_load, a_shift, a_done, a_busy, a_ready, a_pdata} !== {IDLE_VEC, 8'h00}) begin
        errors++;
        $display("FAIL reset_mid_hold k=%0d got=%b required=%b", k,
                 {a_tx, a_load, a_shift, a_done, a_busy, a_ready, a_pdata}, {IDLE_VEC, 8'h00});
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int c = 0; c < 2 * CPB_A; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_tx, a_load, a_shift, a_done, a_busy, a_ready} !== IDLE_VEC) begin
        errors++;
        $display("FAIL reset_mid_after c=%0d got=%b required=%b", c,
                 {a_tx, a_load, a_shift, a_done, a_busy, a_ready}, IDLE_VEC);
      end
    end
    frame_a(8'h81, -1, 8'h00, "reset_mid_81");
  endtask

  task automatic test_stop2();
    logic [DB-1:0] bytes [3];
    logic [5:0] got;
    logic [5:0] exp;
    bytes[0] = 8'h01;
    bytes[1] = 8'($urandom);
    bytes[2] = 8'($urandom);
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (b_ready !== 1'b1) begin
        errors++;
        $display("FAIL stop2 f=%0d ready got=%b required=1", f, b_ready);
      end
      b_valid = 1'b1;
      b_data  = bytes[f];
      for (int c = 1; c <= m_len(CPB_B, SB_B) + 2; c++) begin
        @(posedge clk); #1;
        b_valid = 1'b0;
        got = {b_tx, b_load, b_shift, b_done, b_busy, b_ready};
        exp = m_vec(bytes[f], CPB_B, SB_B, c);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL stop2 f=%0d c=%0d {tx,load,shift,done,busy,ready} got=%b required=%b",
                   f, c, got, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    int gap;
    int pulse;
    for (int f = 0; f < 8; f++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      pulse = ($urandom_range(0, 1) == 1) ? $urandom_range(2, m_len(CPB_A, SB_A)) : -1;
      frame_a(8'($urandom), pulse, 8'($urandom), "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_soak();
    test_basic();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_stop2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
